// File: rtl/sobel_pkg.sv
// Shared pixel/gradient types and helpers for the Sobel word engine.
package sobel_pkg;
  localparam int unsigned PIX_W        = 8;
  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned WORD_W       = PIX_W * PIX_PER_WORD;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic signed [10:0] grad_t;
  typedef logic [9:0]        sum_t;

  localparam pix_t MAG_SAT = 8'd255;

  // Weighted 1-2-1 sum; the middle tap is doubled.
  function automatic sum_t wsum(pix_t a, pix_t b, pix_t c);
    return sum_t'(a) + {1'b0, b, 1'b0} + sum_t'(c);
  endfunction
endpackage

// File: rtl/sobel_word_engine_if.sv
// Window-in / edge-out bus of the Sobel word engine.
interface sobel_word_engine_if;
  import sobel_pkg::*;

  logic              write_en;
  logic [WORD_W-1:0] w0, w1, w2, w3, w4, w5;
  logic [WORD_W-1:0] edge_word;
  logic              edge_valid;
  logic [6:0]        edge_col;
  logic [15:0]       edge_row;

  modport master (output write_en, w0, w1, w2, w3, w4, w5,
                  input  edge_word, edge_valid, edge_col, edge_row);
  modport slave  (input  write_en, w0, w1, w2, w3, w4, w5,
                  output edge_word, edge_valid, edge_col, edge_row);
endinterface

// File: rtl/sobel_pixel_kernel.sv
// One-pixel 3x3 Sobel magnitude, three register stages.
// Optional binarisation selected by macro SOBEL_THRESHOLD_EN.
module sobel_pixel_kernel
  import sobel_pkg::*;
#(
  parameter pix_t THRESHOLD = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s1_en,
  input  logic       s2_en,
  input  logic       s3_en,
  input  pix_t [2:0] top_px,
  input  pix_t [2:0] mid_px,
  input  pix_t [2:0] bot_px,
  output pix_t       result
);
  sum_t        l_q, l_d, r_q, r_d, t_q, t_d, b_q, b_d;
  grad_t       gx_q, gx_d, gy_q, gy_d;
  pix_t        res_q, res_d;
  logic [10:0] ax, ay, mag;
  pix_t        sat;

  // Stage 1: weighted column/row sums around the centre
  always_comb begin
    l_d = l_q;
    r_d = r_q;
    t_d = t_q;
    b_d = b_q;
    if (s1_en) begin
      l_d = wsum(top_px[0], mid_px[0], bot_px[0]);
      r_d = wsum(top_px[2], mid_px[2], bot_px[2]);
      t_d = wsum(top_px[0], top_px[1], top_px[2]);
      b_d = wsum(bot_px[0], bot_px[1], bot_px[2]);
    end
  end

  // Stage 2: signed horizontal and vertical gradients
  always_comb begin
    gx_d = gx_q;
    gy_d = gy_q;
    if (s2_en) begin
      gx_d = $signed({1'b0, r_q}) - $signed({1'b0, l_q});
      gy_d = $signed({1'b0, b_q}) - $signed({1'b0, t_q});
    end
  end

  // Stage 3: L1 magnitude, saturate, optional binarise
  always_comb begin
    ax    = gx_q[10] ? -gx_q : gx_q;
    ay    = gy_q[10] ? -gy_q : gy_q;
    mag   = ax + ay;
    sat   = (mag > {3'b000, MAG_SAT}) ? MAG_SAT : mag[7:0];
    res_d = res_q;
    if (s3_en) begin
`ifdef SOBEL_THRESHOLD_EN
      res_d = (sat > THRESHOLD) ? '1 : '0;
`else
      res_d = sat;
`endif
    end
  end

`ifndef SOBEL_THRESHOLD_EN
  pix_t unused_threshold;
  assign unused_threshold = THRESHOLD;
`endif

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      l_q   <= '0;
      r_q   <= '0;
      t_q   <= '0;
      b_q   <= '0;
      gx_q  <= '0;
      gy_q  <= '0;
      res_q <= '0;
    end else begin
      l_q   <= l_d;
      r_q   <= r_d;
      t_q   <= t_d;
      b_q   <= b_d;
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      res_q <= res_d;
    end
  end

  assign result = res_q;
endmodule

// File: rtl/sobel_word_engine.sv
// Sobel word engine: 4 pixels per word, position tracking and
// qualification of the 3-row window. Optional feature macro:
// SOBEL_THRESHOLD_EN (binarise each output byte against THRESHOLD).
module sobel_word_engine
  import sobel_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 78,
  parameter pix_t        THRESHOLD  = 8'd64
) (
  input logic                clk,
  input logic                rst,
  sobel_word_engine_if.slave bus
);
  logic        we_q, we_d;
  logic [6:0]  col_q, col_d;
  logic [15:0] row_q, row_d;
  logic        qual;
  logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [6:0]  col1_q, col1_d, col2_q, col2_d, col3_q, col3_d;
  logic [15:0] row1_q, row1_d, row2_q, row2_d, row3_q, row3_d;

  logic [2*WORD_W-1:0] top_win, mid_win, bot_win;
  pix_t [2*PIX_PER_WORD-1:0] top_px, mid_px, bot_px;
  logic [WORD_W-1:0] edge_word_w;

  // Unpack each row into p0..p7, p0 = leftmost byte of the older word
  always_comb begin
    top_win = {bus.w0, bus.w1};
    mid_win = {bus.w2, bus.w3};
    bot_win = {bus.w4, bus.w5};
    for (int unsigned i = 0; i < 2 * PIX_PER_WORD; i++) begin
      top_px[i] = top_win[2*WORD_W-1-PIX_W*i -: PIX_W];
      mid_px[i] = mid_win[2*WORD_W-1-PIX_W*i -: PIX_W];
      bot_px[i] = bot_win[2*WORD_W-1-PIX_W*i -: PIX_W];
    end
  end

  // Column/row position and window qualification
  always_comb begin
    we_d  = bus.write_en;
    col_d = col_q;
    row_d = row_q;
    if (we_q) begin
      if (col_q == 7'(LINE_WORDS - 1)) begin
        col_d = '0;
        if (row_q != '1) row_d = row_q + 16'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end
    qual = we_q && (row_q >= 16'd2) && (col_q != '0);
  end

  // Valid bits and position tags travel with the data
  always_comb begin
    v1_d   = qual;
    v2_d   = v1_q;
    v3_d   = v2_q;
    col1_d = qual ? col_q  : col1_q;
    row1_d = qual ? row_q  : row1_q;
    col2_d = v1_q ? col1_q : col2_q;
    row2_d = v1_q ? row1_q : row2_q;
    col3_d = v2_q ? col2_q : col3_q;
    row3_d = v2_q ? row2_q : row3_q;
  end

  // Control and tag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      col1_q <= '0;
      row1_q <= '0;
      col2_q <= '0;
      row2_q <= '0;
      col3_q <= '0;
      row3_q <= '0;
    end else begin
      we_q   <= we_d;
      col_q  <= col_d;
      row_q  <= row_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      col1_q <= col1_d;
      row1_q <= row1_d;
      col2_q <= col2_d;
      row2_q <= row2_d;
      col3_q <= col3_d;
      row3_q <= row3_d;
    end
  end

  for (genvar c = 0; c < PIX_PER_WORD; c++) begin : g_kernel
    sobel_pixel_kernel #(.THRESHOLD(THRESHOLD)) u_kernel (
      .clk   (clk),
      .rst   (rst),
      .s1_en (qual),
      .s2_en (v1_q),
      .s3_en (v2_q),
      .top_px(top_px[c+2:c]),
      .mid_px(mid_px[c+2:c]),
      .bot_px(bot_px[c+2:c]),
      .result(edge_word_w[WORD_W-1-PIX_W*c -: PIX_W])
    );
  end

  assign bus.edge_word  = edge_word_w;
  assign bus.edge_valid = v3_q;
  assign bus.edge_col   = col3_q;
  assign bus.edge_row   = row3_q;
endmodule

// File: tb/tb_sobel_word_engine.sv
// Randomised self-checking bench for sobel_word_engine with a
// queue-based arithmetic reference model.
module tb_sobel_word_engine;
  localparam int unsigned LW  = 78;
  localparam int          THR = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_word_engine_if bus();

  sobel_word_engine #(.LINE_WORDS(LW), .THRESHOLD(8'd64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          due;
    logic [31:0] word;
    int          col;
    int          row;
  } exp_t;

  exp_t        exp_q[$];
  int          checks    = 0;
  int          errors    = 0;
  int          edge_cnt  = 0;
  int          words     = 0;
  logic [31:0] last_word = '0;
  logic [31:0] nxt[6];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h, expected %h", tag, edge_cnt, got, exp);
    end
  endtask

  function automatic int px(input logic [31:0] older, input logic [31:0] newer, input int i);
    logic [63:0] r;
    r = {older, newer};
    return int'(r[63-8*i -: 8]);
  endfunction

  // Direct 3x3 Sobel on integer pixels for centres p1..p4
  function automatic logic [31:0] sobel_ref();
    int p[3][8];
    int gx, gy, mag;
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 8; i++)
        p[r][i] = px(nxt[2*r], nxt[2*r+1], i);
    for (int c = 1; c <= 4; c++) begin
      gx  = (p[0][c+1] + 2*p[1][c+1] + p[2][c+1]) - (p[0][c-1] + 2*p[1][c-1] + p[2][c-1]);
      gy  = (p[2][c-1] + 2*p[2][c] + p[2][c+1]) - (p[0][c-1] + 2*p[0][c] + p[0][c+1]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag > 255) mag = 255;
`ifdef SOBEL_THRESHOLD_EN
      mag = (mag > THR) ? 255 : 0;
`endif
      res = (res << 8) | 32'(mag);
    end
    return res;
  endfunction

  task automatic apply_window();
    bus.w0 = nxt[0]; bus.w1 = nxt[1]; bus.w2 = nxt[2];
    bus.w3 = nxt[3]; bus.w4 = nxt[4]; bus.w5 = nxt[5];
  endtask

  task automatic rand_window();
    int   base;
    logic [31:0] w;
    if ($urandom_range(0, 1) == 0) begin
      for (int j = 0; j < 6; j++) nxt[j] = $urandom;
    end else begin
      base = $urandom_range(0, 255);
      for (int j = 0; j < 6; j++) begin
        w = '0;
        for (int b = 0; b < 4; b++) w = (w << 8) | 32'((base + $urandom_range(0, 31)) % 256);
        nxt[j] = w;
      end
    end
  endtask

  task automatic set_rows(input logic [31:0] older, input logic [31:0] newer);
    for (int j = 0; j < 3; j++) begin
      nxt[2*j]   = older;
      nxt[2*j+1] = newer;
    end
  endtask

  // One clock: drive controls, advance the window like the upstream
  // shift path would, update the model and compare outputs.
  task automatic tick(input bit we, input bit rs);
    exp_t e;
    int   col, row;
    bus.write_en = we;
    rst          = rs;
    @(posedge clk);
    edge_cnt++;
    #1;
    if (rs) begin
      exp_q.delete();
      words     = 0;
      last_word = '0;
    end else if (we) begin
      apply_window();
      col = words % LW;
      row = words / LW;
      if (row > 65535) row = 65535;
      if (row >= 2 && col != 0) begin
        e.due  = edge_cnt + 3;
        e.word = sobel_ref();
        e.col  = col;
        e.row  = row;
        exp_q.push_back(e);
      end
      words++;
    end else begin
      bus.w0 = $urandom; bus.w1 = $urandom; bus.w2 = $urandom;
      bus.w3 = $urandom; bus.w4 = $urandom; bus.w5 = $urandom;
    end

    if (exp_q.size() != 0 && exp_q[0].due == edge_cnt) begin
      e = exp_q.pop_front();
      check_val("edge_valid", 32'(bus.edge_valid), 32'd1);
      check_val("edge_word", bus.edge_word, e.word);
      check_val("edge_col", 32'(bus.edge_col), 32'(e.col));
      check_val("edge_row", 32'(bus.edge_row), 32'(e.row));
      last_word = e.word;
    end else begin
      check_val("no_valid", 32'(bus.edge_valid), 32'd0);
      check_val("word_hold", bus.edge_word, last_word);
    end
    if (rs) begin
      check_val("rst_col", 32'(bus.edge_col), 32'd0);
      check_val("rst_row", 32'(bus.edge_row), 32'd0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.write_en = 1'b0;
    set_rows('0, '0);
    apply_window();
    repeat (3) tick(1'b0, 1'b1);

    // Flat image: three full lines, all magnitudes zero
    set_rows(32'h80808080, 32'h80808080);
    for (int i = 0; i < 3 * int'(LW); i++) tick(1'b1, 1'b0);

    // Vertical step between older and newer words
    set_rows(32'h00000000, 32'hFFFFFFFF);
    for (int i = 0; i < int'(LW); i++) tick(1'b1, 1'b0);

    // Magnitudes right at and just above the threshold
    set_rows(32'h00001000, 32'h00000000);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    nxt[4] = 32'h00001100;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);

    // Random windows with random write_en gaps
    for (int i = 0; i < 600; i++) begin
      rand_window();
      tick($urandom_range(0, 9) < 7, 1'b0);
    end
    repeat (6) tick(1'b0, 1'b0);

    // Latency: isolated pulse at row 2, col 5
    repeat (2) tick(1'b0, 1'b1);
    for (int i = 0; i < 2 * int'(LW) + 5; i++) begin
      rand_window();
      tick(1'b1, 1'b0);
    end
    repeat (6) tick(1'b0, 1'b0);
    rand_window();
    tick(1'b1, 1'b0);
    repeat (6) tick(1'b0, 1'b0);

    // Reset with three qualified entries in flight
    for (int i = 0; i < 3; i++) begin
      rand_window();
      tick(1'b1, 1'b0);
    end
    repeat (2) tick(1'b0, 1'b1);
    repeat (6) tick(1'b0, 1'b0);
    for (int i = 0; i < 2 * int'(LW) + 4; i++) begin
      rand_window();
      tick(1'b1, 1'b0);
    end
    repeat (6) tick(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
